// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types, constants and helpers for the data-memory controller
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus between the load/store datapath and the controller
interface dmem_ctrl_if;
  import mips_mem_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [WORD_W-1:0]         req_addr;
  logic [WORD_W-1:0]         req_wdata;
  logic [BYTES_PER_WORD-1:0] req_be;
  logic                      resp_valid;
  logic [WORD_W-1:0]         resp_rdata;
  logic                      resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_ctrl_bank.sv
// rtl/dmem_ctrl_bank.sv - byte-enable word RAM with synchronous write and combinational read
module dmem_bank
  import mips_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [BYTES_PER_WORD-1:0]    be,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]            wdata,
  output logic [WORD_W-1:0]            rdata
);

  // Left unreset so contents survive a controller reset and can be preloaded.
  logic [WORD_W-1:0] mem [MEM_DEPTH];

  // Write each enabled byte lane on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // The controller registers this on its commit edge, so the read is combinational.
  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - fixed-latency data-memory controller with alignment and range checking
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic      clk,
  input  logic      reset,
  dmem_ctrl_if.slave bus
);

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'(BYTES_PER_WORD);
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  dmem_state_t               state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      we_q;
  logic [WORD_W-1:0]         addr_q;
  logic [WORD_W-1:0]         wdata_q;
  logic [BYTES_PER_WORD-1:0] be_q;
  logic [WORD_W-1:0]         rdata_q;
  logic                      err_q;

  logic                      accept;
  logic                      commit;
  logic                      acc_err;
  logic [WORD_W-1:0]         bank_rdata;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign commit  = (state_q == BUSY) && (cnt_q == 4'd0);
  // Range check uses the whole address so aliases above the array are rejected.
  assign acc_err = is_misaligned(addr_q) || ({1'b0, addr_q} >= MEM_BYTES);

  dmem_bank #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (commit && we_q && !acc_err),
    .be    (be_q),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, count down the access latency, then pulse the response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance; held stable while the access is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  // Response data and error are loaded on the commit edge and held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= (acc_err || we_q) ? '0 : bank_rdata;
      err_q   <= acc_err;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - randomized self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] mdl [0:1023];

  dmem_ctrl_if bus ();
  dmem_ctrl_if bus3 ();

  dmem_ctrl #(.MEM_DEPTH(1024), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_ctrl #(.MEM_DEPTH(1024), .LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mask = mask | (32'hFF << (8 * i));
    end
    return (old & ~mask) | (wd & mask);
  endfunction

  // Reference: word-addressed memory of 1024 words; anything unaligned or past 4 KiB is an error.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [3:0] be,
                                       output logic [31:0] exp_rd, output logic exp_err);
    exp_err = (addr % 4 != 0) || (addr >= 32'd4096);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (we) mdl[addr / 4] = merge(mdl[addr / 4], wd, be);
      else    exp_rd = mdl[addr / 4];
    end
  endfunction

  // Issues one request on the LATENCY=2 controller; reports latency in edges and pulse length.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat, output int plen);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat  = -1;
    plen = 0;
    rd   = 32'h0;
    er   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) begin
        if (lat < 0) begin
          lat = i;
          rd  = bus.resp_rdata;
          er  = bus.resp_err;
        end
        plen++;
      end else if (lat >= 0) begin
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, plen;
    logic [31:0] a;
    for (int w = 0; w < 17; w++) begin
      a = (w == 16) ? 32'hFFC : 32'(w * 4);
      model_access(1'b1, a, 32'h0, 4'hF, erd, eer);
      access(1'b1, a, 32'h0, 4'hF, rd, er, lat, plen);
      total++;
      if (er !== eer || lat != 2) begin
        bad++; $display("FAIL init_store addr=%h err=%b lat=%0d exp err=%b lat=2", a, er, lat, eer);
      end
    end
  endtask

  task automatic test_directed;
    logic        t_we [12]   = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] t_addr [12] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h12, 32'h10,
                                 32'h13, 32'h1000, 32'hFFC, 32'h10, 32'h10, 32'hFFFFFFFC};
    logic [31:0] t_wd [12]   = '{32'h1234, 0, 32'hAABBCCDD, 0, 32'hFFFFFFFF, 0,
                                 0, 0, 0, 32'h12345678, 0, 0};
    logic [3:0]  t_be [12]   = '{4'hF, 4'hF, 4'b0010, 4'hF, 4'hF, 4'hF,
                                 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF};
    logic [31:0] t_rd [12]   = '{0, 32'h1234, 0, 32'hCC34, 0, 32'hCC34,
                                 0, 0, 0, 0, 32'hCC34, 0};
    logic        t_er [12]   = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1};
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, plen;
    for (int k = 0; k < 12; k++) begin
      model_access(t_we[k], t_addr[k], t_wd[k], t_be[k], erd, eer);
      access(t_we[k], t_addr[k], t_wd[k], t_be[k], rd, er, lat, plen);
      total++;
      if (rd !== t_rd[k]) begin bad++; $display("FAIL dir_rdata row=%0d got=%h exp=%h", k, rd, t_rd[k]); end
      total++;
      if (er !== t_er[k]) begin bad++; $display("FAIL dir_err row=%0d got=%b exp=%b", k, er, t_er[k]); end
      total++;
      if (lat != 2 || plen != 1) begin
        bad++; $display("FAIL dir_timing row=%0d lat=%0d pulse=%0d exp lat=2 pulse=1", k, lat, plen);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, plen;
    int seen;
    while (bus.req_ready !== 1'b1) begin @(posedge clk); #1; end
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hDEADBEEF;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", bus.resp_rdata); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", bus.resp_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_nopulse got=%0d pulses exp=0", seen); end
    model_access(1'b0, 32'h20, 32'h0, 4'hF, erd, eer);
    access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, plen);
    total++; if (rd !== erd || rd !== 32'h0) begin bad++; $display("FAIL midrst_keep got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, a, wd;
    logic er, eer, we;
    logic [3:0] be;
    int lat, plen, r;
    for (int k = 0; k < 60; k++) begin
      r  = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = ($urandom | 32'h1000) & 32'hFFFFFFFC;
      else             a = 32'hFFC;
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      model_access(we, a, wd, be, erd, eer);
      access(we, a, wd, be, rd, er, lat, plen);
      total++;
      if (rd !== erd || er !== eer) begin
        bad++; $display("FAIL rand_resp k=%0d we=%b addr=%h got rd=%h err=%b exp rd=%h err=%b",
                        k, we, a, rd, er, erd, eer);
      end
      total++;
      if (lat != 2 || plen != 1) begin
        bad++; $display("FAIL rand_timing k=%0d lat=%0d pulse=%0d exp lat=2 pulse=1", k, lat, plen);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic v [30];
    logic rdy [30];
    int last, run, started;
    int pulses;
    bus3.req_we    = 1'b1;
    bus3.req_addr  = 32'h0;
    bus3.req_wdata = 32'h0;
    bus3.req_be    = 4'h0;
    bus3.req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      v[c]   = bus3.resp_valid;
      rdy[c] = bus3.req_ready;
    end
    bus3.req_valid = 1'b0;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (v[c] === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          total++;
          if (c - last != 5) begin bad++; $display("FAIL b2b_period got=%0d exp=5", c - last); end
        end
        last = c;
      end
    end
    total++; if (pulses < 5) begin bad++; $display("FAIL b2b_pulses got=%0d exp>=5", pulses); end
    run = 0;
    started = 1;
    for (int c = 0; c < 30; c++) begin
      if (rdy[c] === 1'b1) begin
        if (started != 0) begin
          total++;
          if (run != 4) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=4", run); end
        end
        run = 0;
        started = 1;
      end else begin
        run++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_be     = 4'h0;
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = 32'h0;
    bus3.req_wdata = 32'h0;
    bus3.req_be    = 4'h0;
    reset = 1'b1;
    #2;
    test_reset();
    test_init();
    test_directed();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
